unibus_ram: RTL
===============

# unibus_ram

Unibus slave memory card for the simulation board: a block of 16-bit words that answers DATI/DATIP/DATO/DATOB master cycles by driving data and SSYN onto the wire-ANDed Unibus. It sits beside the M9312 ROM card. It consumes the active-high (inverted) bus address, control, data and MSYN lines. Its active-high `d_out_h` and `ssyn_out_h` are inverted and ANDed into `bus_d_l` and `bus_ssyn_l`, so the simulated 11/34 and the Zynq bus master can run against main memory with real bus timing.

## Interface
Parameters:
- `BASE`, default 18'o000000: byte address of the first word; must be even and WORDS-aligned.
- `WORDS`, default 4096: number of 16-bit words; must be a power of two, at most 65536.
- `DESKEW`, default 8: clock cycles (10 ns each) waited after MSYN before sampling A/C/D.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `CLOCK`  in  1  100 MHz clock.
  - `RESET`  in  1  asynchronous active-high reset.
- `a_in_h`  in  18  bus address, active-high.
- `c_in_h`  in  2  bus function: 00 DATI, 01 DATIP, 10 DATO, 11 DATOB.
- `d_in_h`  in  16  bus data, active-high.
- `msyn_in_h`  in  1  master sync.
- `init_in_h`  in  1  bus init.
- `d_out_h`  out  16  read data driven onto the bus; 0 when not driving.
- `ssyn_out_h`  out  1  slave sync.
- `busy_out_h`  out  1  high during a clear sweep; always 0 without the macro.

## Operation
- Address match: `a_in_h[17:1]` lies in BASE/2 .. BASE/2+WORDS-1. Word index = (a_in_h − BASE) >> 1, truncated to log2(WORDS) bits.
- States: IDLE, DESKEW, ACCESS, HOLD, WAITLO.
- IDLE:
  - Rising edge of the registered `msyn_in_h` with a matching address and `busy_out_h`=0 → DESKEW, counter loaded with DESKEW−1.
  - Rising edge with a non-matching address → WAITLO. No response is given.
- DESKEW:
  - Counter decrements each cycle.
  - When it reaches 0 → ACCESS.
  - If `msyn_in_h` goes low first → IDLE, with no memory access.
- ACCESS (1 cycle): A, C and D are sampled this cycle.
  - DATI/DATIP: the word is read into the output register.
  - DATO: the full word is written.
  - DATOB with a_in_h[0]=0: d[7:0] is written to the low byte only.
  - DATOB with a_in_h[0]=1: d[15:8] is written to the high byte only.
  - Next state is HOLD.
- HOLD:
  - `ssyn_out_h`=1.
  - `d_out_h` = read word for DATI/DATIP; 0 for DATO/DATOB.
  - When `msyn_in_h` is sampled low, the block drops `ssyn_out_h` and `d_out_h` to 0 and returns to IDLE.
- WAITLO: waits for `msyn_in_h` low, then returns to IDLE. This prevents re-triggering within a foreign cycle.
- DATIP has no read-modify-write lock. It behaves as DATI; the following DATO is an ordinary cycle.
- `init_in_h`=1: forces IDLE with `ssyn_out_h`=0 and `d_out_h`=0 at the next clock edge. It holds them there while asserted. Memory contents are preserved unless the macro below is enabled.

## Timing
- Reset values: `ssyn_out_h`=0, `d_out_h`=0, `busy_out_h`=0, state IDLE. Memory contents are not reset.
- Read latency: `msyn_in_h` is registered on edge 0 and detected in IDLE on edge 1. ACCESS occurs on edge DESKEW+1, and `ssyn_out_h` and `d_out_h` are valid after edge DESKEW+2.
- With DESKEW=8, SSYN rises 10 cycles (100 ns) after MSYN.
- SSYN deassert latency: 2 cycles after `msyn_in_h` falls (1 register stage plus 1 state update).
- `d_out_h` becomes valid on the same edge as `ssyn_out_h` and drops on the same edge as `ssyn_out_h`.
- Write occurs on the ACCESS edge. A read of the same word in the next bus cycle returns the new data.
- Asserting RESET in any state clears all outputs immediately, with no clock edge needed. Any write not yet committed in ACCESS is lost.

## Configuration
- `UNIBUS_RAM_INIT_CLEAR_EN`:
  - Defined: a rising edge of `init_in_h` starts a clear sweep that writes 0 to one word per cycle, from index 0 to WORDS−1.
    - `busy_out_h`=1 for exactly WORDS cycles.
    - MSYN cycles that start during the sweep get no response.
    - A cycle already in HOLD is aborted by init as normal.
    - RESET stops the sweep, leaving memory partially cleared.
  - Undefined: no sweep; `busy_out_h` is tied to 0 and init only resets the FSM.

## Test plan
- DATO 16'o123456 to BASE+2, MSYN low after SSYN, then DATI BASE+2 → `d_out_h`=16'o123456, and SSYN rises exactly DESKEW+2 cycles after MSYN.
- Word 16'o000000 at BASE+4, then DATOB BASE+5 with d=16'o177400, then DATI BASE+4 → 16'o177400. DATOB BASE+4 with d=16'o000377 → 16'o177777.
- DATI at BASE+2*WORDS (out of range) with MSYN held 50 cycles → `ssyn_out_h` stays 0 and `d_out_h` stays 0 throughout.
- DATO BASE+0 of 16'o000001 with MSYN dropped after 3 cycles (DESKEW=8), then DATI BASE+0 → previous value returned, no SSYN on the aborted cycle.
- RESET pulsed while in HOLD → `ssyn_out_h`=0 and `d_out_h`=0 before the next clock edge; a following DATI responds normally.
- With `UNIBUS_RAM_INIT_CLEAR_EN`: fill words with 16'o052525, pulse init → `busy_out_h` high for WORDS cycles; DATI during the sweep gets no SSYN; DATI afterward → 0.

Source files
------------

// File: rtl/unibus_ram.sv
// ---------------------------------------------------------------------------
// unibus_ram -- Unibus slave memory card for the simulation board.
//
// This block holds WORDS 16-bit words at byte address BASE. It answers the
// DATI/DATIP/DATO/DATOB master cycles. After MSYN rises, it waits DESKEW
// clocks so that A/C/D can settle, and then performs the access. It drives
// SSYN and the read data until MSYN drops.
//
// Parameters:
//   BASE    byte address of word 0 (even, aligned to 2*WORDS)
//   WORDS   number of 16-bit words (power of two, <= 65536)
//   DESKEW  clocks waited after MSYN before A/C/D are sampled (>= 1)
//
// Ports (all bus-side signals are active-high, i.e. already inverted):
//   CLOCK       in   100 MHz clock
//   RESET       in   asynchronous active-high reset
//   a_in_h      in   [17:0] bus address
//   c_in_h      in   [1:0]  bus function: 00 DATI, 01 DATIP, 10 DATO, 11 DATOB
//   d_in_h      in   [15:0] bus data
//   msyn_in_h   in   master sync
//   init_in_h   in   bus init
//   d_out_h     out  [15:0] read data to the bus, 0 when not driving
//   ssyn_out_h  out  slave sync
//   busy_out_h  out  clear sweep in progress
//
// Optional feature: define UNIBUS_RAM_INIT_CLEAR_EN to make a rising edge
// of init_in_h zero the whole memory, one word per clock. When the macro is
// undefined, busy_out_h is tied to 0 and init only resets the FSM.
// ---------------------------------------------------------------------------
module unibus_ram #(
    parameter logic [17:0] BASE   = 18'o000000,
    parameter int unsigned WORDS  = 4096,
    parameter int unsigned DESKEW = 8
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic [15:0] d_in_h,
    input  logic        msyn_in_h,
    input  logic        init_in_h,
    output logic [15:0] d_out_h,
    output logic        ssyn_out_h,
    output logic        busy_out_h
);

    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CW = (DESKEW > 1) ? $clog2(DESKEW) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DESKEW - 1);
    // One-past-the-end byte address. It is computed in 19 bits so that a
    // window ending at the top of the 18-bit space does not wrap.
    localparam logic [18:0] LIMIT = 19'(BASE) + 19'(2 * WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESKEW,
        S_ACCESS,
        S_HOLD,
        S_WAITLO
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_msyn;
    logic            r_msyn_q;
    logic [15:0]     r_mem [WORDS];

    logic            w_hit;
    logic [AW-1:0]   w_idx;
    logic [15:0]     w_rd;
    logic            w_acc_wr;
    logic            w_we_lo;
    logic            w_we_hi;
    logic            w_busy;
    logic [AW-1:0]   w_clr_idx;

    assign w_hit = ({1'b0, a_in_h} >= {1'b0, BASE}) && ({1'b0, a_in_h} < LIMIT);
    assign w_idx = AW'((a_in_h - BASE) >> 1);
    assign w_rd  = r_mem[w_idx];

    // An access is abandoned if init is present on the ACCESS edge,
    // because init forces IDLE on that same edge.
    assign w_acc_wr = (r_state == S_ACCESS) && !init_in_h && c_in_h[1];
    assign w_we_lo  = w_acc_wr && (!c_in_h[0] || !a_in_h[0]);
    assign w_we_hi  = w_acc_wr && (!c_in_h[0] ||  a_in_h[0]);

`ifdef UNIBUS_RAM_INIT_CLEAR_EN
    logic            r_init_q;
    logic            r_busy;
    logic [AW-1:0]   r_clr_idx;

    // A rising init edge arms the sweep. The memory port then clears
    // r_clr_idx on each of the next WORDS edges.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_init_q  <= 1'b0;
            r_busy    <= 1'b0;
            r_clr_idx <= '0;
        end else begin
            r_init_q <= init_in_h;
            if (init_in_h && !r_init_q) begin
                r_busy    <= 1'b1;
                r_clr_idx <= '0;
            end else if (r_busy) begin
                if (r_clr_idx == AW'(WORDS - 1))
                    r_busy <= 1'b0;
                else
                    r_clr_idx <= r_clr_idx + 1'b1;
            end
        end
    end

    assign w_busy    = r_busy;
    assign w_clr_idx = r_clr_idx;
`else
    assign w_busy    = 1'b0;
    assign w_clr_idx = '0;
`endif

    assign busy_out_h = w_busy;

    // The memory array is never reset. RESET forces the FSM (and the sweep)
    // idle, so no write enable can reach the array while RESET is high.
    always_ff @(posedge CLOCK) begin
        if (w_busy) begin
            r_mem[w_clr_idx] <= '0;
        end else begin
            if (w_we_lo)
                r_mem[w_idx][7:0]  <= d_in_h[7:0];
            if (w_we_hi)
                r_mem[w_idx][15:8] <= d_in_h[15:8];
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_msyn     <= 1'b0;
            r_msyn_q   <= 1'b0;
            ssyn_out_h <= 1'b0;
            d_out_h    <= '0;
        end else begin
            r_msyn   <= msyn_in_h;
            r_msyn_q <= r_msyn;
            if (init_in_h) begin
                r_state    <= S_IDLE;
                ssyn_out_h <= 1'b0;
                d_out_h    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Only a fresh MSYN edge starts a cycle. A foreign or
                        // refused cycle is parked in WAITLO until MSYN drops.
                        if (r_msyn && !r_msyn_q) begin
                            if (w_hit && !w_busy) begin
                                r_state <= S_DESKEW;
                                r_cnt   <= CNT_LOAD;
                            end else begin
                                r_state <= S_WAITLO;
                            end
                        end
                    end
                    S_DESKEW: begin
                        if (!r_msyn)
                            r_state <= S_IDLE;
                        else if (r_cnt == '0)
                            r_state <= S_ACCESS;
                        else
                            r_cnt <= r_cnt - 1'b1;
                    end
                    S_ACCESS: begin
                        ssyn_out_h <= 1'b1;
                        d_out_h    <= c_in_h[1] ? 16'h0000 : w_rd;
                        r_state    <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (!r_msyn) begin
                            ssyn_out_h <= 1'b0;
                            d_out_h    <= '0;
                            r_state    <= S_IDLE;
                        end
                    end
                    S_WAITLO: begin
                        if (!r_msyn)
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
